// File: rtl/sawtooth_gen_fsm_if.sv
// Control/data bundle between the button/switch front end and the sawtooth generator.
// The generator takes the slave side. The driver of the buttons and switches takes the master side.
interface sawtooth_gen_fsm_if #(
  parameter int WIDTH = 8
);
  logic             ce_i;
  logic             v_i;
  logic             st_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] din_i;
  logic [WIDTH-1:0] cnt_o;
  logic [WIDTH-1:0] n1_o;
  logic [WIDTH-1:0] n2_o;
  logic [WIDTH-1:0] dind_o;
  logic [2:0]       state_o;
  logic             dir_o;
  logic             wrap_o;
  logic             run_o;

  modport master (
    output ce_i, v_i, st_i, mode_i, din_i,
    input  cnt_o, n1_o, n2_o, dind_o, state_o, dir_o, wrap_o, run_o
  );

  modport slave (
    input  ce_i, v_i, st_i, mode_i, din_i,
    output cnt_o, n1_o, n2_o, dind_o, state_o, dir_o, wrap_o, run_o
  );
endinterface

// File: rtl/sawtooth_gen_fsm.sv
// Bound-capture FSM with an up-saw, down-saw or triangle counter between two captured bounds.
// The counter advances on a one-cycle tick enable and supports pause/resume.
module sawtooth_gen_fsm #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sawtooth_gen_fsm_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GOT_N1 = 3'd1,
    S_GOT_N2 = 3'd2,
    S_RUN    = 3'd3,
    S_HOLD   = 3'd4
  } state_e;

  localparam logic [1:0]     M_UP   = 2'd0;
  localparam logic [1:0]     M_DOWN = 2'd1;
  localparam logic [1:0]     M_TRI  = 2'd2;
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  // a + STEP, clamped to ceil; evaluated one bit wider so it never wraps
  function automatic logic [WIDTH-1:0] add_ceil(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] ceil_v);
    if (({1'b0, a} + STEP_X) > {1'b0, ceil_v}) begin
      return ceil_v;
    end
    return WIDTH'({1'b0, a} + STEP_X);
  endfunction

  // a - STEP, clamped to floor; the comparison form avoids an underflowing subtract
  function automatic logic [WIDTH-1:0] sub_floor(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] floor_v);
    if ({1'b0, a} < ({1'b0, floor_v} + STEP_X)) begin
      return floor_v;
    end
    return WIDTH'({1'b0, a} - STEP_X);
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] n1_q, n1_d;
  logic [WIDTH-1:0] n2_q, n2_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             run_q, run_d;
  logic             v_prev_q, st_prev_q;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;

  logic             v_rise, st_rise;
  logic [WIDTH-1:0] start_lo, start_hi;
  logic [WIDTH-1:0] tick_cnt;
  logic             tick_dir, tick_wrap;
  logic             above_hi, below_lo;

  assign v_rise   = bus.v_i  & ~v_prev_q;
  assign st_rise  = bus.st_i & ~st_prev_q;
  assign start_lo = (n1_q < n2_q) ? n1_q : n2_q;
  assign start_hi = (n1_q < n2_q) ? n2_q : n1_q;
  assign above_hi = ({1'b0, cnt_q} + STEP_X) > {1'b0, hi_q};
  assign below_lo = {1'b0, cnt_q} < ({1'b0, lo_q} + STEP_X);

  // One counting step for the latched mode, used only when a tick lands in RUN
  always_comb begin
    tick_cnt  = cnt_q;
    tick_dir  = dir_q;
    tick_wrap = 1'b0;
    case (mode_q)
      M_DOWN: begin
        if (below_lo) begin
          tick_cnt  = hi_q;
          tick_wrap = 1'b1;
        end else begin
          tick_cnt = sub_floor(cnt_q, lo_q);
        end
      end
      M_TRI: begin
        if (!dir_q) begin
          if (cnt_q == hi_q) begin
            tick_dir  = 1'b1;
            tick_cnt  = sub_floor(cnt_q, lo_q);
            tick_wrap = 1'b1;
          end else begin
            tick_cnt = add_ceil(cnt_q, hi_q);
          end
        end else begin
          if (cnt_q == lo_q) begin
            tick_dir  = 1'b0;
            tick_cnt  = add_ceil(cnt_q, hi_q);
            tick_wrap = 1'b1;
          end else begin
            tick_cnt = sub_floor(cnt_q, lo_q);
          end
        end
      end
      default: begin
        if (above_hi) begin
          tick_cnt  = lo_q;
          tick_wrap = 1'b1;
        end else begin
          tick_cnt = add_ceil(cnt_q, hi_q);
        end
      end
    endcase
  end

  // Button events take priority over a coincident tick; v wins over st
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    case (state_q)
      S_IDLE: begin
        if (v_rise) begin
          n1_d    = bus.din_i;
          state_d = S_GOT_N1;
        end
      end
      S_GOT_N1: begin
        if (v_rise) begin
          n2_d    = bus.din_i;
          state_d = S_GOT_N2;
        end
      end
      S_GOT_N2: begin
        if (v_rise) begin
          n1_d    = bus.din_i;
          state_d = S_GOT_N1;
        end else if (st_rise) begin
          mode_d  = (bus.mode_i == 2'd3) ? M_UP : bus.mode_i;
          lo_d    = start_lo;
          hi_d    = start_hi;
          state_d = S_RUN;
          if (bus.mode_i == M_DOWN) begin
            cnt_d = start_hi;
            dir_d = 1'b1;
          end else begin
            cnt_d = start_lo;
            dir_d = 1'b0;
          end
        end
      end
      S_RUN: begin
        if (v_rise) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (st_rise) begin
          state_d = S_HOLD;
        end else if (bus.ce_i) begin
          cnt_d  = tick_cnt;
          dir_d  = tick_dir;
          wrap_d = tick_wrap;
        end
      end
      S_HOLD: begin
        if (v_rise) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (st_rise) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_d = (state_d == S_RUN);

  // Control and visible registers; button history resets high so a held button cannot fire
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n1_q      <= '0;
      n2_q      <= '0;
      dir_q     <= 1'b0;
      wrap_q    <= 1'b0;
      run_q     <= 1'b0;
      v_prev_q  <= 1'b1;
      st_prev_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      dir_q     <= dir_d;
      wrap_q    <= wrap_d;
      run_q     <= run_d;
      v_prev_q  <= bus.v_i;
      st_prev_q <= bus.st_i;
    end
  end

  // Run configuration: only read after a start loads it
  always_ff @(posedge clk_i) begin
    mode_q <= mode_d;
    lo_q   <= lo_d;
    hi_q   <= hi_d;
  end

  assign bus.cnt_o   = cnt_q;
  assign bus.n1_o    = n1_q;
  assign bus.n2_o    = n2_q;
  assign bus.state_o = state_q;
  assign bus.dir_o   = dir_q;
  assign bus.wrap_o  = wrap_q;
  assign bus.run_o   = run_q;

  always_comb begin
    case (state_q)
      S_IDLE, S_GOT_N1: bus.dind_o = bus.din_i;
      S_GOT_N2:         bus.dind_o = n2_q;
      default:          bus.dind_o = cnt_q;
    endcase
  end

endmodule

// File: tb/tb_sawtooth_gen_fsm.sv
// Bench for sawtooth_gen_fsm: directed scenarios plus a random run against a reference model.
// Two instances are used, one with STEP=1 and one with STEP=2.
module tb_sawtooth_gen_fsm;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic ce, v, st;
  logic [1:0]   mode;
  logic [W-1:0] din;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sawtooth_gen_fsm_if #(.WIDTH(W)) ifa ();
  sawtooth_gen_fsm_if #(.WIDTH(W)) ifb ();

  assign ifa.ce_i = ce;  assign ifa.v_i = v;  assign ifa.st_i = st;
  assign ifa.mode_i = mode;  assign ifa.din_i = din;
  assign ifb.ce_i = ce;  assign ifb.v_i = v;  assign ifb.st_i = st;
  assign ifb.mode_i = mode;  assign ifb.din_i = din;

  sawtooth_gen_fsm #(.WIDTH(W), .STEP(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  sawtooth_gen_fsm #(.WIDTH(W), .STEP(2)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  // Reference model: index 0 mirrors dut_a (step 1), index 1 mirrors dut_b (step 2)
  int m_state[2], m_cnt[2], m_n1[2], m_n2[2], m_dir[2], m_wrap[2];
  int m_mode[2], m_lo[2], m_hi[2];
  int m_pv, m_pst;

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_step();
    bit vr, sr;
    int s;
    vr = (v === 1'b1) && (m_pv == 0);
    sr = (st === 1'b1) && (m_pst == 0);
    for (int k = 0; k < 2; k++) begin
      s = k + 1;
      m_wrap[k] = 0;
      if (rst) begin
        m_state[k] = 0; m_cnt[k] = 0; m_n1[k] = 0; m_n2[k] = 0; m_dir[k] = 0;
      end else if (m_state[k] == 0) begin
        if (vr) begin m_n1[k] = din; m_state[k] = 1; end
      end else if (m_state[k] == 1) begin
        if (vr) begin m_n2[k] = din; m_state[k] = 2; end
      end else if (m_state[k] == 2) begin
        if (vr) begin
          m_n1[k] = din; m_state[k] = 1;
        end else if (sr) begin
          m_mode[k] = (mode == 3) ? 0 : int'(mode);
          m_lo[k] = imin(m_n1[k], m_n2[k]);
          m_hi[k] = imax(m_n1[k], m_n2[k]);
          m_state[k] = 3;
          m_cnt[k] = (m_mode[k] == 1) ? m_hi[k] : m_lo[k];
          m_dir[k] = (m_mode[k] == 1) ? 1 : 0;
        end
      end else begin
        if (vr) begin
          m_state[k] = 0; m_cnt[k] = 0;
        end else if (sr) begin
          m_state[k] = (m_state[k] == 3) ? 4 : 3;
        end else if (m_state[k] == 3 && ce) begin
          if (m_mode[k] == 0) begin
            if (m_cnt[k] + s > m_hi[k]) begin m_cnt[k] = m_lo[k]; m_wrap[k] = 1; end
            else m_cnt[k] = m_cnt[k] + s;
          end else if (m_mode[k] == 1) begin
            if (m_cnt[k] - s < m_lo[k]) begin m_cnt[k] = m_hi[k]; m_wrap[k] = 1; end
            else m_cnt[k] = m_cnt[k] - s;
          end else if (m_dir[k] == 0) begin
            if (m_cnt[k] == m_hi[k]) begin
              m_dir[k] = 1; m_cnt[k] = imax(m_cnt[k] - s, m_lo[k]); m_wrap[k] = 1;
            end else m_cnt[k] = imin(m_cnt[k] + s, m_hi[k]);
          end else begin
            if (m_cnt[k] == m_lo[k]) begin
              m_dir[k] = 0; m_cnt[k] = imin(m_cnt[k] + s, m_hi[k]); m_wrap[k] = 1;
            end else m_cnt[k] = imax(m_cnt[k] - s, m_lo[k]);
          end
        end
      end
    end
    if (rst) begin m_pv = 1; m_pst = 1; end
    else begin m_pv = int'(v); m_pst = int'(st); end
  endtask

  function automatic logic [37:0] model_vec(input int k);
    int d;
    d = (m_state[k] <= 1) ? int'(din) : ((m_state[k] == 2) ? m_n2[k] : m_cnt[k]);
    return {3'(m_state[k]), 8'(m_cnt[k]), 8'(m_n1[k]), 8'(m_n2[k]), 8'(d),
            1'(m_dir[k]), 1'(m_wrap[k]), 1'(m_state[k] == 3)};
  endfunction

  function automatic logic [37:0] dut_vec(input int k);
    if (k == 0)
      return {ifa.state_o, ifa.cnt_o, ifa.n1_o, ifa.n2_o, ifa.dind_o, ifa.dir_o, ifa.wrap_o, ifa.run_o};
    return {ifb.state_o, ifb.cnt_o, ifb.n1_o, ifb.n2_o, ifb.dind_o, ifb.dir_o, ifb.wrap_o, ifb.run_o};
  endfunction

  task automatic tick(input bit c, input bit vv, input bit ss);
    @(negedge clk);
    ce = c; v = vv; st = ss;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0);
  endtask

  task automatic go_idle();
    tick(0, 0, 0); tick(0, 1, 0); tick(0, 0, 0);
  endtask

  task automatic load_start(input int a, input int b, input int m);
    tick(0, 0, 0);
    din = W'(a); tick(0, 1, 0); tick(0, 0, 0);
    din = W'(b); tick(0, 1, 0); tick(0, 0, 0);
    mode = 2'(m); tick(0, 0, 1); tick(0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1; ce = 0; v = 0; st = 0; mode = 0; din = 8'h5A;
    tick(0, 0, 0); tick(0, 0, 0);
    n_checks++;
    if ({ifa.state_o, ifa.cnt_o, ifa.n1_o, ifa.n2_o, ifa.dir_o, ifa.wrap_o, ifa.run_o} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d cnt=%0d n1=%0d n2=%0d, required all 0",
               ifa.state_o, ifa.cnt_o, ifa.n1_o, ifa.n2_o);
    end
    rst = 0;
    tick(0, 0, 0);
    n_checks++;
    if (ifa.dind_o !== 8'h5A) begin
      n_fail++;
      $display("FAIL idle_dind: got %0d required %0d", ifa.dind_o, 8'h5A);
    end
  endtask

  task automatic test_up_saw();
    int exp_c[5] = '{10, 11, 12, 13, 10};
    int exp_w[5] = '{0, 0, 0, 0, 1};
    load_start(10, 13, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick(1, 0, 0);
      n_checks++;
      if (ifa.cnt_o !== W'(exp_c[i]) || ifa.wrap_o !== 1'(exp_w[i]) || ifa.run_o !== 1'b1) begin
        n_fail++;
        $display("FAIL up_saw[%0d]: cnt=%0d wrap=%0d run=%0d, required cnt=%0d wrap=%0d run=1",
                 i, ifa.cnt_o, ifa.wrap_o, ifa.run_o, exp_c[i], exp_w[i]);
      end
      idle(3);
    end
    n_checks++;
    if (ifa.wrap_o !== 1'b0) begin
      n_fail++;
      $display("FAIL up_saw_wrap_width: wrap=%0d required 0", ifa.wrap_o);
    end
  endtask

  task automatic test_down_saw();
    go_idle();
    load_start(20, 5, 1);
    n_checks++;
    if (ifa.cnt_o !== 8'd20 || ifa.dir_o !== 1'b1) begin
      n_fail++;
      $display("FAIL down_start: cnt=%0d dir=%0d, required cnt=20 dir=1", ifa.cnt_o, ifa.dir_o);
    end
    for (int i = 1; i <= 16; i++) begin
      tick(1, 0, 0);
      n_checks++;
      if (ifa.cnt_o !== W'((i == 16) ? 20 : 20 - i) || ifa.wrap_o !== (i == 16)) begin
        n_fail++;
        $display("FAIL down_saw[%0d]: cnt=%0d wrap=%0d, required cnt=%0d wrap=%0d",
                 i, ifa.cnt_o, ifa.wrap_o, (i == 16) ? 20 : 20 - i, i == 16);
      end
      idle(3);
    end
  endtask

  task automatic test_triangle();
    int exp_c[8] = '{3, 5, 7, 8, 6, 4, 3, 5};
    int exp_w[8] = '{0, 0, 0, 0, 1, 0, 0, 1};
    go_idle();
    load_start(3, 8, 2);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick(1, 0, 0);
      n_checks++;
      if (ifb.cnt_o !== W'(exp_c[i]) || ifb.wrap_o !== 1'(exp_w[i])) begin
        n_fail++;
        $display("FAIL triangle[%0d]: cnt=%0d wrap=%0d, required cnt=%0d wrap=%0d",
                 i, ifb.cnt_o, ifb.wrap_o, exp_c[i], exp_w[i]);
      end
      idle(3);
    end
  endtask

  task automatic test_pause_resume();
    go_idle();
    load_start(10, 20, 0);
    tick(1, 0, 0); tick(1, 0, 0);
    tick(0, 0, 1);
    n_checks++;
    if (ifa.state_o !== 3'd4 || ifa.cnt_o !== 8'd12 || ifa.run_o !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_enter: state=%0d cnt=%0d run=%0d, required state=4 cnt=12 run=0",
               ifa.state_o, ifa.cnt_o, ifa.run_o);
    end
    for (int i = 0; i < 10; i++) tick(1, 0, 0);
    n_checks++;
    if (ifa.cnt_o !== 8'd12) begin
      n_fail++;
      $display("FAIL hold_frozen: cnt=%0d required 12", ifa.cnt_o);
    end
    tick(1, 0, 1);
    n_checks++;
    if (ifa.state_o !== 3'd3 || ifa.cnt_o !== 8'd12) begin
      n_fail++;
      $display("FAIL resume: state=%0d cnt=%0d, required state=3 cnt=12", ifa.state_o, ifa.cnt_o);
    end
    tick(1, 0, 0);
    n_checks++;
    if (ifa.cnt_o !== 8'd13) begin
      n_fail++;
      $display("FAIL resume_count: cnt=%0d required 13", ifa.cnt_o);
    end
    tick(1, 1, 1);
    n_checks++;
    if (ifa.state_o !== 3'd0 || ifa.cnt_o !== 8'd0 || ifa.n1_o !== 8'd10 || ifa.n2_o !== 8'd20) begin
      n_fail++;
      $display("FAIL v_st_same_cycle: state=%0d cnt=%0d n1=%0d n2=%0d, required 0 0 10 20",
               ifa.state_o, ifa.cnt_o, ifa.n1_o, ifa.n2_o);
    end
  endtask

  task automatic test_equal_bounds();
    load_start(7, 7, 2);
    for (int i = 1; i <= 3; i++) begin
      tick(1, 0, 0);
      n_checks++;
      if (ifa.cnt_o !== 8'd7 || ifa.wrap_o !== 1'b1 || ifa.dir_o !== 1'(i % 2)) begin
        n_fail++;
        $display("FAIL equal_bounds[%0d]: cnt=%0d wrap=%0d dir=%0d, required 7 1 %0d",
                 i, ifa.cnt_o, ifa.wrap_o, ifa.dir_o, i % 2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1; tick(1, 0, 0);
    n_checks++;
    if ({ifa.state_o, ifa.cnt_o, ifa.n1_o, ifa.n2_o, ifa.dir_o, ifa.wrap_o, ifa.run_o} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_mid_run: state=%0d cnt=%0d n1=%0d n2=%0d dir=%0d, required all 0",
               ifa.state_o, ifa.cnt_o, ifa.n1_o, ifa.n2_o, ifa.dir_o);
    end
    din = 8'd42;
    tick(0, 1, 0);
    rst = 0;
    tick(0, 1, 0); tick(0, 1, 0); tick(0, 1, 0);
    n_checks++;
    if (ifa.state_o !== 3'd0) begin
      n_fail++;
      $display("FAIL held_v_through_reset: state=%0d required 0", ifa.state_o);
    end
    tick(0, 0, 0); tick(0, 1, 0);
    n_checks++;
    if (ifa.state_o !== 3'd1 || ifa.n1_o !== 8'd42) begin
      n_fail++;
      $display("FAIL capture_after_release: state=%0d n1=%0d, required 1 42", ifa.state_o, ifa.n1_o);
    end
  endtask

  task automatic test_random();
    logic [37:0] act, exp_v;
    rst = 1; tick(0, 0, 0); rst = 0;
    for (int i = 0; i < 3000; i++) begin
      mode = 2'($urandom_range(0, 3));
      din  = W'($urandom_range(0, 48));
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0));
      for (int k = 0; k < 2; k++) begin
        act   = dut_vec(k);
        exp_v = model_vec(k);
        n_checks++;
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d: got %h required %h", i, k, act, exp_v);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_saw();
    test_down_saw();
    test_triangle();
    test_pause_resume();
    test_equal_bounds();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sawtooth_gen_fsm.md
Name: sawtooth_gen_fsm

Overview:
Parametrised successor of the current sawtooth counter FSM. It captures two bounds N1 and N2 through the select button, runs a counter between them on a clock-enable tick, and adds down-sawtooth and triangle modes, a configurable step and pause/resume. It sits between the input synchronisers and the BCD/LED display path. It runs on the full 50 MHz clock with a tick enable, not on a divided clock.

Parameters:
WIDTH, 8, width of din_i, bounds and counter
STEP, 1, counter increment per tick (1..2^WIDTH-1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
ce_i  in  1  count tick, one clk_i cycle wide (e.g. 4 Hz from divider)
v_i  in  1  select button level, already synchronised
st_i  in  1  start/pause button level, already synchronised
mode_i  in  2  0=up saw, 1=down saw, 2=triangle, 3=treated as 0; sampled at start
din_i  in  WIDTH  bound data from switches
cnt_o  out  WIDTH  counter value
n1_o  out  WIDTH  captured N1
n2_o  out  WIDTH  captured N2
dind_o  out  WIDTH  value for 7-seg display
state_o  out  3  state code for debug digit
dir_o  out  1  1=counting down
wrap_o  out  1  one-cycle pulse on wrap or triangle reversal
run_o  out  1  high in RUN

Behaviour:
- Reset, when rst_i is high at a clk_i edge: state IDLE; cnt/n1/n2/dir/wrap = 0. Button history registers reset to 1, so a button held through reset does not fire.
- Edge detect: rise = level & ~prev, evaluated every clk_i regardless of ce_i. Effects are visible on the next clk_i edge.
- lo = min(N1,N2), hi = max(N1,N2), fixed at start.
- States: IDLE=0, GOT_N1=1, GOT_N2=2, RUN=3, HOLD=4.
- IDLE: v rise -> N1<=din_i, go to GOT_N1. st ignored.
- GOT_N1: v rise -> N2<=din_i, go to GOT_N2. st ignored.
- GOT_N2: v rise -> N1<=din_i, go to GOT_N1 (re-entry).
- GOT_N2: st rise -> latch mode, go to RUN. Start value: mode 1 -> cnt=hi, dir=1; otherwise cnt=lo, dir=0.
- RUN: st rise -> HOLD, with cnt frozen and ce ignored. HOLD: st rise -> RUN.
- RUN/HOLD: v rise -> IDLE, cnt<=0. N1 and N2 are retained.
- v rise and st rise in the same cycle: v wins.
- RUN counting on ce_i; all arithmetic is WIDTH+1 bits, with no overflow wrap.
- Up saw: if cnt+STEP>hi then cnt<=lo, wrap_o=1; else cnt+=STEP.
- Down saw: if cnt<lo+STEP then cnt<=hi, wrap_o=1; else cnt-=STEP.
- Triangle, dir=0: if cnt==hi then dir<=1, cnt<=max(cnt-STEP,lo), wrap_o=1; else cnt<=min(cnt+STEP,hi).
- Triangle, dir=1: mirror of dir=0 at lo.
- lo==hi: cnt stays constant and wrap_o pulses on every tick (triangle dir toggles).
- A ce_i in the same cycle as an st/v rise: the state transition takes priority and no count occurs.
- wrap_o is registered and high exactly one clk_i cycle, aligned with the updated cnt_o.
- dind_o: IDLE/GOT_N1 -> din_i (live); GOT_N2 -> n2; RUN/HOLD -> cnt.
- run_o = (state==RUN). All outputs are registered except dind_o, which is a mux of registers and din_i.

Test Plan:
- Up saw: WIDTH=8, STEP=1, load N1=10, N2=13, mode 0, start, ce every 4 clk -> cnt 10,11,12,13,10; wrap_o pulses once, on 13->10.
- Down saw, swapped bounds: N1=20, N2=5, mode 1 -> cnt starts at 20, dir_o=1, runs 20..5 then 20; wrap_o pulses at 5->20.
- Triangle STEP=2: N1=3, N2=8, mode 2 -> 3,5,7,8,6,4,3,5; wrap_o pulses at 8->6 and at 3->5.
- Pause/resume and edge cases: st rise in RUN at cnt=12 -> HOLD (state_o=4); 10 ce ticks leave cnt=12; st rise -> RUN, continues 13. Simultaneous v+st rise in RUN -> IDLE, cnt=0, n1/n2 unchanged. lo==hi=7 -> cnt=7 and wrap_o on every tick.
- Reset: rst_i high mid-RUN -> next cycle all outputs 0, state_o=0. Holding v_i high through reset release produces no capture until v_i falls and rises again.
